pid_mux_controller: RTL and testbench

Time-multiplexed, NUM_CH-channel fixed-point PID controller. It replaces the separate per-motor and wall-follower PID instances with one shared datapath: one multiplier and one accumulator, with per-channel gains, integrator state and derivative history. On each sample strobe it captures all setpoints and feedbacks, then processes the channels one after another. It adds integrator clamping, conditional-integration anti-windup and an overrun flag, which the single-channel controller does not have.

---
 rtl/pid_mux_controller.sv | 207 ++++++++++++++++++++
 tb/tb_pid_mux_controller.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pid_mux_controller.sv
// Time-shared NUM_CH-channel PID: one multiplier and one accumulator, five cycles per channel.
// A strobe captures all inputs; strobes that arrive mid-sweep are dropped and flagged in overrun.
module pid_mux_controller #(
    parameter int NUM_CH        = 4,
    parameter int PV_WIDTH      = 8,
    parameter int INT_WIDTH     = 8,
    parameter int FRAC_WIDTH    = 8,
    parameter int CONTROL_WIDTH = 18,
    parameter int INTEG_WIDTH   = 24
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic                                          clk_en,
    input  logic                                          en,
    input  logic [NUM_CH*(INT_WIDTH+FRAC_WIDTH)-1:0]      k_p,
    input  logic [NUM_CH*(INT_WIDTH+FRAC_WIDTH)-1:0]      k_i,
    input  logic [NUM_CH*(INT_WIDTH+FRAC_WIDTH)-1:0]      k_d,
    input  logic [NUM_CH*PV_WIDTH-1:0]                    setpoint,
    input  logic [NUM_CH*PV_WIDTH-1:0]                    feedback,
    output logic [NUM_CH*(PV_WIDTH+1)-1:0]                error,
    output logic [NUM_CH*CONTROL_WIDTH-1:0]               control_out,
    output logic                                          valid,
    output logic                                          busy,
    output logic                                          overrun
);
    localparam int G         = INT_WIDTH + FRAC_WIDTH;
    localparam int EW        = PV_WIDTH + 1;
    localparam int DW        = PV_WIDTH + 2;
    localparam int IW1       = INTEG_WIDTH + 1;
    localparam int PW        = G + 1 + INTEG_WIDTH;
    localparam int ACC_WIDTH = G + INTEG_WIDTH + 3;
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    localparam logic signed [IW1-1:0]       IMAX = {2'b00, {(INTEG_WIDTH-1){1'b1}}};
    localparam logic signed [IW1-1:0]       IMIN = -IMAX;
    localparam logic signed [ACC_WIDTH-1:0] CMAX = ACC_WIDTH'({1'b0, {(CONTROL_WIDTH-1){1'b1}}});
    localparam logic signed [ACC_WIDTH-1:0] CMIN = ~CMAX;

    typedef enum logic [2:0] {IDLE, ERR, MP, MI, MD, OUT} state_t;
    state_t state, state_nxt;

    logic [CH_W-1:0] ch_idx;
    logic            last_ch;

    logic [NUM_CH*G-1:0]        kp_sh, ki_sh, kd_sh;
    logic [NUM_CH*PV_WIDTH-1:0] sp_sh, fb_sh;

    logic signed [INTEG_WIDTH-1:0] integ    [NUM_CH];
    logic signed [EW-1:0]          e_prev   [NUM_CH];
    logic [1:0]                    sat_flag [NUM_CH];

    logic signed [EW-1:0]          e_cur;
    logic signed [DW-1:0]          de_cur;
    logic signed [INTEG_WIDTH-1:0] integ_cand;
    logic signed [ACC_WIDTH-1:0]   acc;

    logic [PV_WIDTH-1:0]           sp_cur, fb_cur;
    logic signed [EW-1:0]          e_new;
    logic signed [DW-1:0]          de_new;
    logic signed [IW1-1:0]         integ_sum;
    logic signed [INTEG_WIDTH-1:0] integ_clamped;
    logic signed [INTEG_WIDTH-1:0] integ_use;
    logic                          freeze;
    logic [G-1:0]                  mul_gain;
    logic signed [INTEG_WIDTH-1:0] mul_op;
    logic signed [PW-1:0]          product;
    logic signed [ACC_WIDTH-1:0]   acc_shift;
    logic                          sat_hi, sat_lo;
    logic [CONTROL_WIDTH-1:0]      u;

    assign busy    = (state != IDLE);
    assign last_ch = (ch_idx == CH_W'(NUM_CH - 1));

    assign sp_cur    = sp_sh[ch_idx*PV_WIDTH +: PV_WIDTH];
    assign fb_cur    = fb_sh[ch_idx*PV_WIDTH +: PV_WIDTH];
    assign e_new     = $signed({1'b0, sp_cur}) - $signed({1'b0, fb_cur});
    assign de_new    = DW'(e_new) - DW'(e_prev[ch_idx]);
    assign integ_sum = IW1'(integ[ch_idx]) + IW1'(e_new);

    always_comb begin
        integ_clamped = integ_sum[INTEG_WIDTH-1:0];
        if (integ_sum > IMAX)
            integ_clamped = IMAX[INTEG_WIDTH-1:0];
        else if (integ_sum < IMIN)
            integ_clamped = IMIN[INTEG_WIDTH-1:0];
    end

    // Hold the integrator only while pushing further into the rail the output is already on.
    assign freeze    = ((sat_flag[ch_idx] == 2'b01) && (e_cur > 0)) ||
                       ((sat_flag[ch_idx] == 2'b11) && (e_cur < 0));
    assign integ_use = freeze ? integ[ch_idx] : integ_cand;

    always_comb begin
        mul_gain = '0;
        mul_op   = '0;
        case (state)
            MP: begin
                mul_gain = kp_sh[ch_idx*G +: G];
                mul_op   = INTEG_WIDTH'(e_cur);
            end
            MI: begin
                mul_gain = ki_sh[ch_idx*G +: G];
                mul_op   = integ_use;
            end
            MD: begin
                mul_gain = kd_sh[ch_idx*G +: G];
                mul_op   = INTEG_WIDTH'(de_cur);
            end
            default: ;
        endcase
    end

    assign product   = PW'($signed({1'b0, mul_gain})) * PW'(mul_op);
    assign acc_shift = acc >>> FRAC_WIDTH;
    assign sat_hi    = (acc_shift > CMAX);
    assign sat_lo    = (acc_shift < CMIN);

    always_comb begin
        u = acc_shift[CONTROL_WIDTH-1:0];
        if (sat_hi)
            u = CMAX[CONTROL_WIDTH-1:0];
        else if (sat_lo)
            u = CMIN[CONTROL_WIDTH-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (!en) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (clk_en) state_nxt = ERR;
                ERR:     state_nxt = MP;
                MP:      state_nxt = MI;
                MI:      state_nxt = MD;
                MD:      state_nxt = OUT;
                OUT:     state_nxt = last_ch ? IDLE : ERR;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset || !en) begin
            // en low clears exactly like reset, only synchronously.
            for (int i = 0; i < NUM_CH; i++) begin
                integ[i]    <= '0;
                e_prev[i]   <= '0;
                sat_flag[i] <= '0;
            end
            kp_sh       <= '0;
            ki_sh       <= '0;
            kd_sh       <= '0;
            sp_sh       <= '0;
            fb_sh       <= '0;
            ch_idx      <= '0;
            e_cur       <= '0;
            de_cur      <= '0;
            integ_cand  <= '0;
            acc         <= '0;
            error       <= '0;
            control_out <= '0;
            valid       <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (clk_en && state != IDLE)
                overrun <= 1'b1;
            case (state)
                IDLE: if (clk_en) begin
                    kp_sh  <= k_p;
                    ki_sh  <= k_i;
                    kd_sh  <= k_d;
                    sp_sh  <= setpoint;
                    fb_sh  <= feedback;
                    ch_idx <= '0;
                end
                ERR: begin
                    error[ch_idx*EW +: EW] <= e_new;
                    e_cur      <= e_new;
                    de_cur     <= de_new;
                    integ_cand <= integ_clamped;
                    acc        <= '0;
                end
                MP, MI, MD: acc <= acc + ACC_WIDTH'(product);
                OUT: begin
                    control_out[ch_idx*CONTROL_WIDTH +: CONTROL_WIDTH] <= u;
                    integ[ch_idx]    <= integ_use;
                    e_prev[ch_idx]   <= e_cur;
                    sat_flag[ch_idx] <= sat_hi ? 2'b01 : (sat_lo ? 2'b11 : 2'b00);
                    if (last_ch)
                        valid <= 1'b1;
                    else
                        ch_idx <= ch_idx + 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_pid_mux_controller.sv
// Directed-vector bench for pid_mux_controller, built with a 10-bit control word so saturation is reachable.
module tb_pid_mux_controller;
    localparam int NCH = 4;
    localparam int PV  = 8;
    localparam int G   = 16;
    localparam int CW  = 10;
    localparam int EW  = PV + 1;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              clk_en = 1'b0;
    logic              en = 1'b1;
    logic [NCH*G-1:0]  k_p = '0, k_i = '0, k_d = '0;
    logic [NCH*PV-1:0] setpoint = '0, feedback = '0;
    logic [NCH*EW-1:0] error;
    logic [NCH*CW-1:0] control_out;
    logic              valid, busy, overrun;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pid_mux_controller #(
        .NUM_CH(NCH), .PV_WIDTH(PV), .INT_WIDTH(8), .FRAC_WIDTH(8),
        .CONTROL_WIDTH(CW), .INTEG_WIDTH(24)
    ) dut (
        .clk(clk), .reset(reset), .clk_en(clk_en), .en(en),
        .k_p(k_p), .k_i(k_i), .k_d(k_d),
        .setpoint(setpoint), .feedback(feedback),
        .error(error), .control_out(control_out),
        .valid(valid), .busy(busy), .overrun(overrun)
    );

    function automatic logic signed [CW-1:0] co(input int ch);
        return control_out[ch*CW +: CW];
    endfunction

    function automatic logic signed [EW-1:0] er(input int ch);
        return error[ch*EW +: EW];
    endfunction

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Leaves the caller at the falling edge just after the strobe edge T0.
    task automatic strobe();
        @(negedge clk);
        clk_en = 1'b1;
        @(negedge clk);
        clk_en = 1'b0;
    endtask

    task automatic set_ch(input int ch, input logic [15:0] kp, input logic [15:0] ki,
                          input logic [15:0] kd, input logic [7:0] sp, input logic [7:0] fb);
        k_p[ch*G +: G]       = kp;
        k_i[ch*G +: G]       = ki;
        k_d[ch*G +: G]       = kd;
        setpoint[ch*PV +: PV] = sp;
        feedback[ch*PV +: PV] = fb;
    endtask

    task automatic clear_all();
        k_p = '0; k_i = '0; k_d = '0; setpoint = '0; feedback = '0;
        @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        en = 1'b1;
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (valid !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (valid !== 1'b1) begin
            errors++;
            $display("FAIL %s valid timeout: no pulse within %0d cycles", name, n);
        end
    endtask

    task automatic count_valid(input string name);
        int nv = 0;
        repeat (30) begin
            @(negedge clk);
            if (valid === 1'b1) nv++;
        end
        checks++;
        if (nv != 0) begin errors++; $display("FAIL %s stray valid: got %0d pulses exp 0", name, nv); end
    endtask

    task automatic test_reset();
        #12;
        checks++; if (error !== '0)       begin errors++; $display("FAIL reset_error got %h exp 0", error); end
        checks++; if (control_out !== '0) begin errors++; $display("FAIL reset_ctrl got %h exp 0", control_out); end
        checks++; if (valid !== 1'b0)     begin errors++; $display("FAIL reset_valid got %b exp 0", valid); end
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (overrun !== 1'b0)   begin errors++; $display("FAIL reset_overrun got %b exp 0", overrun); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_proportional();
        clear_all();
        set_ch(0, 16'h0100, 16'h0, 16'h0, 8'd30, 8'd20);
        set_ch(1, 16'h0080, 16'h0, 16'h0, 8'd17, 8'd20);
        set_ch(2, 16'h0200, 16'h0, 16'h0, 8'd0, 8'd255);
        set_ch(3, 16'h0300, 16'h0, 16'h0, 8'd255, 8'd0);
        strobe();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL prop_busy_t0 got %b exp 1", busy); end
        step(1);
        checks++; if (er(0) !== 10) begin errors++; $display("FAIL prop_err0_t1 got %0d exp 10", er(0)); end
        checks++; if (co(0) !== 0)  begin errors++; $display("FAIL prop_ctrl0_t1 got %0d exp 0", co(0)); end
        step(4);
        checks++; if (co(0) !== 10) begin errors++; $display("FAIL prop_ctrl0_t5 got %0d exp 10", co(0)); end
        step(1);
        checks++; if (er(1) !== -3) begin errors++; $display("FAIL prop_err1_t6 got %0d exp -3", er(1)); end
        step(4);
        checks++; if (co(1) !== -2) begin errors++; $display("FAIL prop_floor_t10 got %0d exp -2", co(1)); end
        step(9);
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL prop_valid_t19 got %b exp 0", valid); end
        checks++; if (busy !== 1'b1)  begin errors++; $display("FAIL prop_busy_t19 got %b exp 1", busy); end
        step(1);
        checks++; if (valid !== 1'b1) begin errors++; $display("FAIL prop_valid_t20 got %b exp 1", valid); end
        checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL prop_busy_t20 got %b exp 0", busy); end
        checks++; if (er(2) !== -255) begin errors++; $display("FAIL prop_err2 got %0d exp -255", er(2)); end
        checks++; if (co(2) !== -510) begin errors++; $display("FAIL prop_ctrl2 got %0d exp -510", co(2)); end
        checks++; if (co(3) !== 511)  begin errors++; $display("FAIL prop_sat3 got %0d exp 511", co(3)); end
        step(1);
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL prop_valid_t21 got %b exp 0", valid); end
    endtask

    task automatic test_integral();
        clear_all();
        set_ch(0, 16'h0, 16'h0100, 16'h0, 8'd30, 8'd20);
        for (int k = 1; k <= 3; k++) begin
            strobe();
            wait_valid("integ");
            checks++;
            if (co(0) !== 10 * k) begin errors++; $display("FAIL integ_sweep%0d got %0d exp %0d", k, co(0), 10 * k); end
        end
    endtask

    task automatic test_derivative();
        clear_all();
        set_ch(0, 16'h0, 16'h0, 16'h0100, 8'd30, 8'd20);
        strobe();
        wait_valid("deriv1");
        checks++; if (co(0) !== 10) begin errors++; $display("FAIL deriv_first got %0d exp 10", co(0)); end
        set_ch(0, 16'h0, 16'h0, 16'h0100, 8'd24, 8'd20);
        strobe();
        wait_valid("deriv2");
        checks++; if (co(0) !== -6) begin errors++; $display("FAIL deriv_second got %0d exp -6", co(0)); end
    endtask

    task automatic test_antiwindup();
        int exp0 [4] = '{511, 511, 150, 140};
        int exp1 [4] = '{-512, -512, -150, -140};
        clear_all();
        set_ch(0, 16'h0400, 16'h0100, 16'h0, 8'd220, 8'd20);
        set_ch(1, 16'h0400, 16'h0100, 16'h0, 8'd0, 8'd200);
        for (int s = 0; s < 4; s++) begin
            if (s == 2) begin
                set_ch(0, 16'h0400, 16'h0100, 16'h0, 8'd20, 8'd30);
                set_ch(1, 16'h0400, 16'h0100, 16'h0, 8'd30, 8'd20);
            end
            strobe();
            wait_valid("antiwindup");
            checks++;
            if (co(0) !== exp0[s]) begin errors++; $display("FAIL aw_ch0_sweep%0d got %0d exp %0d", s, co(0), exp0[s]); end
            checks++;
            if (co(1) !== exp1[s]) begin errors++; $display("FAIL aw_ch1_sweep%0d got %0d exp %0d", s, co(1), exp1[s]); end
        end
    endtask

    task automatic test_overrun();
        clear_all();
        set_ch(0, 16'h0100, 16'h0, 16'h0, 8'd30, 8'd20);
        strobe();
        step(6);
        clk_en = 1'b1;
        step(1);
        clk_en = 1'b0;
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_set got %b exp 1", overrun); end
        wait_valid("ovr");
        checks++; if (co(0) !== 10)     begin errors++; $display("FAIL ovr_ctrl0 got %0d exp 10", co(0)); end
        checks++; if (er(0) !== 10)     begin errors++; $display("FAIL ovr_err0 got %0d exp 10", er(0)); end
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky got %b exp 1", overrun); end
        count_valid("ovr_no_second");
        clear_all();
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear got %b exp 0", overrun); end
        strobe();
        step(19);
        clk_en = 1'b1;
        step(1);
        clk_en = 1'b0;
        checks++; if (valid !== 1'b1)   begin errors++; $display("FAIL ovr_last_valid got %b exp 1", valid); end
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_last_edge got %b exp 1", overrun); end
        step(1);
        checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL ovr_last_ignored busy got %b exp 0", busy); end
    endtask

    task automatic test_en_drop();
        clear_all();
        set_ch(0, 16'h0100, 16'h0100, 16'h0, 8'd30, 8'd20);
        strobe();
        wait_valid("en1");
        checks++; if (co(0) !== 20) begin errors++; $display("FAIL en_first got %0d exp 20", co(0)); end
        strobe();
        step(1);
        clk_en = 1'b1;
        step(1);
        clk_en = 1'b0;
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL en_pre_overrun got %b exp 1", overrun); end
        step(5);
        en = 1'b0;
        step(1);
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL en_busy got %b exp 0", busy); end
        checks++; if (control_out !== '0) begin errors++; $display("FAIL en_ctrl got %h exp 0", control_out); end
        checks++; if (error !== '0)       begin errors++; $display("FAIL en_error got %h exp 0", error); end
        checks++; if (overrun !== 1'b0)   begin errors++; $display("FAIL en_overrun got %b exp 0", overrun); end
        checks++; if (valid !== 1'b0)     begin errors++; $display("FAIL en_valid got %b exp 0", valid); end
        en = 1'b1;
        count_valid("en_no_valid");
        strobe();
        wait_valid("en2");
        checks++; if (co(0) !== 20) begin errors++; $display("FAIL en_integ_cleared got %0d exp 20", co(0)); end
    endtask

    task automatic test_reset_mid();
        clear_all();
        set_ch(0, 16'h0100, 16'h0, 16'h0, 8'd30, 8'd20);
        strobe();
        wait_valid("rst1");
        checks++; if (co(0) !== 10) begin errors++; $display("FAIL rst_pre_ctrl got %0d exp 10", co(0)); end
        strobe();
        step(1);
        clk_en = 1'b1;
        step(1);
        clk_en = 1'b0;
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL rst_pre_overrun got %b exp 1", overrun); end
        checks++; if (er(0) !== 10)     begin errors++; $display("FAIL rst_pre_err got %0d exp 10", er(0)); end
        #2 reset = 1'b1;
        #1;
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
        checks++; if (overrun !== 1'b0)   begin errors++; $display("FAIL rst_overrun got %b exp 0", overrun); end
        checks++; if (control_out !== '0) begin errors++; $display("FAIL rst_ctrl got %h exp 0", control_out); end
        checks++; if (error !== '0)       begin errors++; $display("FAIL rst_error got %h exp 0", error); end
        @(negedge clk);
        reset = 1'b0;
        count_valid("rst_no_valid");
    endtask

    initial begin
        test_reset();
        test_proportional();
        test_integral();
        test_derivative();
        test_antiwindup();
        test_overrun();
        test_en_drop();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
